// File: rtl/one_of_n_rr_mux_if.sv
// Handshake bundle between N producers, the selector and its single consumer.
// master = producer/consumer side, slave = selector side.
interface one_of_n_rr_mux_if #(
    parameter int WIDTH = 8,
    parameter int N     = 6
);
    localparam int SEL_W = $clog2(N);

    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_val;
    logic [N-1:0]       in_rdy;
    logic               mode;
    logic [SEL_W-1:0]   sel;
    logic [WIDTH-1:0]   out_data;
    logic [SEL_W-1:0]   out_id;
    logic               out_val;
    logic               out_rdy;
    logic               err_sel;

    modport master (
        output in_data, in_val, mode, sel, out_rdy,
        input  in_rdy, out_data, out_id, out_val, err_sel
    );

    modport slave (
        input  in_data, in_val, mode, sel, out_rdy,
        output in_rdy, out_data, out_id, out_val, err_sel
    );
endinterface

// File: rtl/one_of_n_rr_mux.sv
// N-way valid/ready selector (explicit select or round-robin) into a one-entry output register; 1-cycle latency.
// in_rdy is low on every channel while the held output is stalled; ONE_OF_N_RR_MUX_SEL_ERR_EN adds sticky err_sel.
module one_of_n_rr_mux #(
    parameter int WIDTH = 8,
    parameter int N     = 6
) (
    input  logic             clk,
    input  logic             rst,
    one_of_n_rr_mux_if.slave bus
);
    localparam int SEL_W = $clog2(N);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_id_q, out_id_d;
    logic             out_val_q, out_val_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic             free;
    logic             xfer;
    logic [N-1:0]     grant;
    logic [SEL_W-1:0] win_id;
    logic [WIDTH-1:0] win_data;

    assign free = (~out_val_q | bus.out_rdy) & ~rst;

    // Out-of-range sel matches no channel, so the null grant falls out naturally.
    always_comb begin
        logic [SEL_W-1:0] cur;
        logic             found;
        grant = '0;
        cur   = ptr_q;
        found = 1'b0;
        if (!bus.mode) begin
            for (int i = 0; i < N; i++) begin
                grant[i] = bus.in_val[i] & (bus.sel == SEL_W'(i));
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                cur = (cur == SEL_W'(N - 1)) ? '0 : cur + 1'b1;
                if (!found && bus.in_val[cur]) begin
                    grant[cur] = 1'b1;
                    found      = 1'b1;
                end
            end
        end
    end

    always_comb begin
        win_id   = '0;
        win_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                win_id   = SEL_W'(i);
                win_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign xfer       = (|grant) & free;
    assign bus.in_rdy = grant & {N{free}};

    always_comb begin
        out_data_d = out_data_q;
        out_id_d   = out_id_q;
        out_val_d  = out_val_q;
        ptr_d      = ptr_q;
        if (xfer) begin
            out_data_d = win_data;
            out_id_d   = win_id;
            out_val_d  = 1'b1;
            ptr_d      = win_id;
        end else if (bus.out_rdy) begin
            out_val_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q <= '0;
            out_id_q   <= '0;
            out_val_q  <= 1'b0;
            ptr_q      <= SEL_W'(N - 1);
        end else begin
            out_data_q <= out_data_d;
            out_id_q   <= out_id_d;
            out_val_q  <= out_val_d;
            ptr_q      <= ptr_d;
        end
    end

    assign bus.out_data = out_data_q;
    assign bus.out_id   = out_id_q;
    assign bus.out_val  = out_val_q;

`ifdef ONE_OF_N_RR_MUX_SEL_ERR_EN
    logic err_sel_q, err_sel_d;

    assign err_sel_d = err_sel_q | (~bus.mode & ({1'b0, bus.sel} >= (SEL_W + 1)'(N)));

    always_ff @(posedge clk) begin
        if (rst) begin
            err_sel_q <= 1'b0;
        end else begin
            err_sel_q <= err_sel_d;
        end
    end

    assign bus.err_sel = err_sel_q;
`else
    assign bus.err_sel = 1'b0;
`endif
endmodule

// File: tb/tb_one_of_n_rr_mux.sv
// Scoreboard bench for one_of_n_rr_mux at WIDTH=8, N=6.
module tb_one_of_n_rr_mux;
    localparam int WIDTH = 8;
    localparam int N     = 6;

    typedef struct packed {
        logic [7:0] d;
        logic [2:0] id;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    one_of_n_rr_mux_if #(.WIDTH(WIDTH), .N(N)) bus ();
    one_of_n_rr_mux #(.WIDTH(WIDTH), .N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    exp_t       sbq[$];
    logic [7:0] chan [N];
    logic       m_val;
    int         m_ptr;
    logic       m_err;
    logic [7:0] last_d;
    logic [2:0] last_id;

    function automatic logic [5:0] model_grant(input logic [5:0] v, input logic m,
                                               input logic [2:0] s, input int p);
        logic [5:0] g;
        logic       found;
        int         j;
        int         si;
        g     = '0;
        found = 1'b0;
        si    = int'(s);
        if (!m) begin
            if (si < N && ((v >> si) & 6'd1) != 6'd0) g = 6'd1 << si;
        end else begin
            for (int k = 1; k <= N; k++) begin
                j = (p + k) % N;
                if (!found && ((v >> j) & 6'd1) != 6'd0) begin
                    g     = 6'd1 << j;
                    found = 1'b1;
                end
            end
        end
        return g;
    endfunction

    // One clock: drives payloads, records expected in_rdy, advances the model and scoreboard.
    task automatic clock_cycle(output logic [5:0] er, output logic [5:0] ar, output logic pushed);
        logic [5:0] g;
        int         j;
        bus.in_data = {chan[5], chan[4], chan[3], chan[2], chan[1], chan[0]};
        #1;
        g      = model_grant(bus.in_val, bus.mode, bus.sel, m_ptr);
        er     = (rst || !(!m_val || bus.out_rdy)) ? 6'd0 : g;
        ar     = bus.in_rdy;
        pushed = 1'b0;
        if (rst) begin
            m_val   = 1'b0;
            m_ptr   = N - 1;
            m_err   = 1'b0;
            last_d  = '0;
            last_id = '0;
            sbq.delete();
        end else begin
            if (er != 6'd0) begin
                j = 0;
                for (int k = 0; k < N; k++) if (((er >> k) & 6'd1) != 6'd0) j = k;
                sbq.push_back('{d: chan[j], id: 3'(j)});
                m_ptr  = j;
                m_val  = 1'b1;
                pushed = 1'b1;
            end else if (bus.out_rdy) begin
                m_val = 1'b0;
            end
`ifdef ONE_OF_N_RR_MUX_SEL_ERR_EN
            if (!bus.mode && bus.sel >= 3'd6) m_err = 1'b1;
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic take(output exp_t e);
        e       = sbq.pop_front();
        last_d  = e.d;
        last_id = e.id;
    endtask

    task automatic test_reset();
        logic [5:0] er, ar;
        logic       p;
        rst = 1'b1;
        bus.in_val = 6'h3f; bus.mode = 1'b1; bus.sel = '0; bus.out_rdy = 1'b1;
        for (int i = 0; i < N; i++) chan[i] = 8'(8'h50 + i);
        clock_cycle(er, ar, p);
        clock_cycle(er, ar, p);
        n_cmp++; if (ar !== 6'd0) begin n_bad++; $display("FAIL reset_in_rdy act=%b exp=000000", ar); end
        n_cmp++; if (bus.out_val !== 1'b0) begin n_bad++; $display("FAIL reset_out_val act=%b exp=0", bus.out_val); end
        n_cmp++; if (bus.out_data !== 8'h00) begin n_bad++; $display("FAIL reset_out_data act=%h exp=00", bus.out_data); end
        n_cmp++; if (bus.out_id !== 3'd0) begin n_bad++; $display("FAIL reset_out_id act=%0d exp=0", bus.out_id); end
        n_cmp++; if (bus.err_sel !== 1'b0) begin n_bad++; $display("FAIL reset_err_sel act=%b exp=0", bus.err_sel); end
        rst = 1'b0;
    endtask

    task automatic test_explicit_select();
        logic [5:0] er, ar;
        logic       p;
        exp_t       e;
        bus.mode = 1'b0; bus.sel = 3'd3; bus.in_val = 6'b001000; bus.out_rdy = 1'b1;
        chan[3] = 8'hA5;
        clock_cycle(er, ar, p);
        n_cmp++; if (ar !== 6'b001000) begin n_bad++; $display("FAIL explicit_in_rdy act=%b exp=001000", ar); end
        n_cmp++; if (bus.out_val !== 1'b1) begin n_bad++; $display("FAIL explicit_out_val act=%b exp=1", bus.out_val); end
        if (p) begin
            take(e);
            n_cmp++; if (bus.out_data !== e.d) begin n_bad++; $display("FAIL explicit_out_data act=%h exp=%h", bus.out_data, e.d); end
            n_cmp++; if (bus.out_id !== e.id) begin n_bad++; $display("FAIL explicit_out_id act=%0d exp=%0d", bus.out_id, e.id); end
        end
        bus.in_val = 6'd0;
        clock_cycle(er, ar, p);
        n_cmp++; if (bus.out_val !== m_val) begin n_bad++; $display("FAIL explicit_drain act=%b exp=%b", bus.out_val, m_val); end
        n_cmp++; if (bus.out_data !== last_d) begin n_bad++; $display("FAIL explicit_drain_data act=%h exp=%h", bus.out_data, last_d); end
    endtask

    task automatic test_null_select();
        logic [5:0] er, ar;
        logic       p;
        bus.mode = 1'b0; bus.in_val = 6'h3f; bus.out_rdy = 1'b1;
        for (int s = 6; s <= 7; s++) begin
            bus.sel = 3'(s);
            clock_cycle(er, ar, p);
            n_cmp++; if (ar !== 6'd0) begin n_bad++; $display("FAIL null_in_rdy sel=%0d act=%b exp=000000", s, ar); end
            n_cmp++; if (bus.out_val !== 1'b0) begin n_bad++; $display("FAIL null_out_val sel=%0d act=%b exp=0", s, bus.out_val); end
            n_cmp++; if (bus.err_sel !== m_err) begin n_bad++; $display("FAIL null_err_sel sel=%0d act=%b exp=%b", s, bus.err_sel, m_err); end
        end
    endtask

    task automatic test_rr_rotation();
        logic [5:0] er, ar;
        logic       p;
        exp_t       e;
        rst = 1'b1; bus.in_val = 6'd0;
        clock_cycle(er, ar, p);
        rst = 1'b0;
        bus.mode = 1'b1; bus.in_val = 6'h3f; bus.out_rdy = 1'b1;
        for (int i = 0; i < N; i++) chan[i] = 8'(8'h10 + i);
        for (int k = 0; k < 7; k++) begin
            clock_cycle(er, ar, p);
            n_cmp++; if (bus.out_val !== 1'b1) begin n_bad++; $display("FAIL rr_out_val step=%0d act=%b exp=1", k, bus.out_val); end
            n_cmp++; if (bus.out_id !== 3'(k % N)) begin n_bad++; $display("FAIL rr_order step=%0d act=%0d exp=%0d", k, bus.out_id, k % N); end
            if (p) begin
                take(e);
                n_cmp++; if (bus.out_data !== e.d) begin n_bad++; $display("FAIL rr_data step=%0d act=%h exp=%h", k, bus.out_data, e.d); end
            end
        end
    endtask

    task automatic test_sparse_wrap();
        logic [5:0] er, ar;
        logic       p;
        exp_t       e;
        logic [2:0] want [3];
        want[0] = 3'd4; want[1] = 3'd0; want[2] = 3'd1;
        bus.mode = 1'b0; bus.sel = 3'd4; bus.in_val = 6'b010000; bus.out_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin bus.mode = 1'b1; bus.in_val = 6'b000011; end
            clock_cycle(er, ar, p);
            n_cmp++; if (ar !== er) begin n_bad++; $display("FAIL sparse_in_rdy step=%0d act=%b exp=%b", k, ar, er); end
            n_cmp++; if (bus.out_id !== want[k]) begin n_bad++; $display("FAIL sparse_id step=%0d act=%0d exp=%0d", k, bus.out_id, want[k]); end
            if (p) take(e);
        end
    endtask

    task automatic test_backpressure();
        logic [5:0] er, ar;
        logic       p;
        exp_t       e;
        bus.mode = 1'b0; bus.sel = 3'd1; bus.in_val = 6'b000010; bus.out_rdy = 1'b1;
        chan[1] = 8'h11; chan[2] = 8'h22;
        clock_cycle(er, ar, p);
        if (p) take(e);
        bus.sel = 3'd2; bus.in_val = 6'b000100; bus.out_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            clock_cycle(er, ar, p);
            n_cmp++; if (ar !== 6'd0) begin n_bad++; $display("FAIL bp_in_rdy step=%0d act=%b exp=000000", k, ar); end
            n_cmp++; if (bus.out_data !== 8'h11) begin n_bad++; $display("FAIL bp_hold step=%0d act=%h exp=11", k, bus.out_data); end
        end
        bus.out_rdy = 1'b1;
        clock_cycle(er, ar, p);
        n_cmp++; if (ar !== 6'b000100) begin n_bad++; $display("FAIL bp_release_rdy act=%b exp=000100", ar); end
        n_cmp++; if (bus.out_val !== 1'b1) begin n_bad++; $display("FAIL bp_release_val act=%b exp=1", bus.out_val); end
        if (p) begin
            take(e);
            n_cmp++; if (bus.out_data !== e.d) begin n_bad++; $display("FAIL bp_release_data act=%h exp=%h", bus.out_data, e.d); end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] er, ar;
        logic       p;
        exp_t       e;
        for (int k = 0; k < 200; k++) begin
            bus.in_val  = 6'($urandom);
            bus.mode    = 1'($urandom_range(0, 1));
            bus.sel     = 3'($urandom_range(0, 7));
            bus.out_rdy = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) chan[i] = 8'($urandom);
            clock_cycle(er, ar, p);
            n_cmp++; if (ar !== er) begin n_bad++; $display("FAIL b2b_in_rdy cyc=%0d act=%b exp=%b", k, ar, er); end
            n_cmp++; if (bus.out_val !== m_val) begin n_bad++; $display("FAIL b2b_out_val cyc=%0d act=%b exp=%b", k, bus.out_val, m_val); end
            n_cmp++; if (bus.err_sel !== m_err) begin n_bad++; $display("FAIL b2b_err_sel cyc=%0d act=%b exp=%b", k, bus.err_sel, m_err); end
            if (p) take(e);
            if (m_val) begin
                n_cmp++; if (bus.out_data !== last_d) begin n_bad++; $display("FAIL b2b_data cyc=%0d act=%h exp=%h", k, bus.out_data, last_d); end
                n_cmp++; if (bus.out_id !== last_id) begin n_bad++; $display("FAIL b2b_id cyc=%0d act=%0d exp=%0d", k, bus.out_id, last_id); end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] er, ar;
        logic       p;
        exp_t       e;
        bus.mode = 1'b0; bus.sel = 3'd5; bus.in_val = 6'h3f; bus.out_rdy = 1'b0;
        chan[5] = 8'h77;
        clock_cycle(er, ar, p);
        if (p) take(e);
        n_cmp++; if (bus.out_val !== m_val) begin n_bad++; $display("FAIL rstmid_pre_val act=%b exp=%b", bus.out_val, m_val); end
        rst = 1'b1;
        clock_cycle(er, ar, p);
        n_cmp++; if (ar !== 6'd0) begin n_bad++; $display("FAIL rstmid_in_rdy act=%b exp=000000", ar); end
        n_cmp++; if (bus.out_val !== 1'b0) begin n_bad++; $display("FAIL rstmid_out_val act=%b exp=0", bus.out_val); end
        n_cmp++; if (bus.out_data !== 8'h00) begin n_bad++; $display("FAIL rstmid_out_data act=%h exp=00", bus.out_data); end
        n_cmp++; if (bus.out_id !== 3'd0) begin n_bad++; $display("FAIL rstmid_out_id act=%0d exp=0", bus.out_id); end
        n_cmp++; if (bus.err_sel !== 1'b0) begin n_bad++; $display("FAIL rstmid_err_sel act=%b exp=0", bus.err_sel); end
        rst = 1'b0;
        bus.mode = 1'b1; bus.in_val = 6'h3f; bus.out_rdy = 1'b1;
        clock_cycle(er, ar, p);
        n_cmp++; if (bus.out_id !== 3'd0) begin n_bad++; $display("FAIL rstmid_first_rr act=%0d exp=0", bus.out_id); end
        n_cmp++; if (bus.out_val !== 1'b1) begin n_bad++; $display("FAIL rstmid_first_val act=%b exp=1", bus.out_val); end
        if (p) take(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bus.in_data = '0; bus.in_val = '0; bus.mode = 1'b0; bus.sel = '0; bus.out_rdy = 1'b0;
        m_val = 1'b0; m_ptr = N - 1; m_err = 1'b0; last_d = '0; last_id = '0;
        test_reset();
        test_explicit_select();
        test_null_select();
        test_rr_rotation();
        test_sparse_wrap();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
